// File: rtl/ascon_spi_loader_pkg.sv
// Shared encodings for the SPI loader: command fields, op codes, ascon mode codes,
// FSM state constants and frame data lengths.
package ascon_spi_loader_pkg;

    localparam logic [1:0] OP_WR_REG   = 2'b00;
    localparam logic [1:0] OP_WR_STATE = 2'b01;
    localparam logic [1:0] OP_RD_STATE = 2'b10;
    localparam logic [1:0] OP_START    = 2'b11;

    typedef enum logic [2:0] {
        MODE_IDLE    = 3'd0,
        MODE_ENCRYPT = 3'd1,
        MODE_DECRYPT = 3'd2,
        MODE_HASH    = 3'd3,
        MODE_XOF     = 3'd4,
        MODE_CXOF    = 3'd5
    } mode_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int REG_LEN = 128;
    localparam int ST_LEN  = 64;

    typedef struct packed {
        logic [1:0] op;
        logic [2:0] sel;
        logic [2:0] mode;
    } cmd_t;

endpackage

// File: rtl/ascon_spi_loader_spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with rise/fall strobes
// derived from the synchronized level.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = q_o & ~prev_q;
    assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/ascon_spi_loader.sv
// SPI mode-0 slave that loads ascon operand registers, streams state bits into the
// core, reads state words back on miso and issues operation start pulses.
module ascon_spi_loader
    import ascon_spi_loader_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int REG_W       = REG_LEN,
    parameter int ST_W        = ST_LEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    input  logic [ST_W-1:0]  S_0_reg,
    input  logic [ST_W-1:0]  S_1_reg,
    input  logic [ST_W-1:0]  S_2_reg,
    input  logic [ST_W-1:0]  S_3_reg,
    input  logic [ST_W-1:0]  S_4_reg,
    output logic [REG_W-1:0] reg0_128b,
    output logic [REG_W-1:0] reg1_128b,
    output logic [REG_W-1:0] reg2_128b,
    output logic [2:0]       operation_mode,
    output logic             operation_ready,
    output logic             state_shift_en,
    output logic [2:0]       state_shift_sel,
    output logic             state_shift_lsb
);

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst_n(rst_n), .d_i(sclk),
        .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst_n(rst_n), .d_i(cs_n),
        .q_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .rst_n(rst_n), .d_i(mosi),
        .q_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );

    logic [1:0]       state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [REG_W-1:0] stage_q, stage_d;
    logic [ST_W-1:0]  out_q, out_d;
    logic [REG_W-1:0] regs_q [3];
    logic [REG_W-1:0] regs_d [3];
    logic [2:0]       mode_q, mode_d;
    logic             ready_q, ready_d;
    logic             sh_en_q, sh_en_d;
    logic [2:0]       sh_sel_q, sh_sel_d;
    logic             sh_lsb_q, sh_lsb_d;

    cmd_t             new_cmd;
    logic [1:0]       cur_op;
    logic [2:0]       cur_sel;
    logic [7:0]       last_idx;
    logic [REG_W-1:0] stage_shift;
    logic [ST_W-1:0]  rd_word;

    // new_cmd is the command byte as it stands once the current mosi bit is included
    assign new_cmd     = cmd_t'({cmd_q[6:0], mosi_s});
    assign cur_op      = cmd_q[7:6];
    assign cur_sel     = cmd_q[5:3];
    assign last_idx    = (cur_op == OP_WR_REG) ? 8'(REG_W - 1) : 8'(ST_W - 1);
    assign stage_shift = {stage_q[REG_W-2:0], mosi_s};

    always_comb begin
        case (new_cmd.sel)
            3'd0:    rd_word = S_0_reg;
            3'd1:    rd_word = S_1_reg;
            3'd2:    rd_word = S_2_reg;
            3'd3:    rd_word = S_3_reg;
            3'd4:    rd_word = S_4_reg;
            default: rd_word = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cmd_d    = cmd_q;
        stage_d  = stage_q;
        out_d    = out_q;
        regs_d   = regs_q;
        mode_d   = mode_q;
        ready_d  = 1'b0;
        sh_en_d  = 1'b0;
        sh_sel_d = sh_sel_q;
        sh_lsb_d = sh_lsb_q;

        // cs_n edges take priority, so a coincident sclk edge is dropped
        if (cs_rise) begin
            state_d = ST_IDLE;
        end else if (cs_fall) begin
            state_d = ST_CMD;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_CMD: begin
                    if (sclk_rise) begin
                        cmd_d = new_cmd;
                        if (cnt_q == 8'd7) begin
                            cnt_d = '0;
                            case (new_cmd.op)
                                OP_WR_REG:   state_d = (new_cmd.sel < 3'd3) ? ST_DATA : ST_DONE;
                                OP_WR_STATE: state_d = (new_cmd.sel < 3'd5) ? ST_DATA : ST_DONE;
                                OP_RD_STATE: begin
                                    state_d = ST_DATA;
                                    out_d   = rd_word;
                                end
                                OP_START: begin
                                    state_d = ST_DONE;
                                    mode_d  = new_cmd.mode;
                                    ready_d = 1'b1;
                                end
                            endcase
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (sclk_rise) begin
                        if (cnt_q <= last_idx) cnt_d = cnt_q + 8'd1;
                        if (cnt_q == last_idx) state_d = ST_DONE;
                        if (cur_op == OP_WR_REG) begin
                            stage_d = stage_shift;
                            if (cnt_q == last_idx) regs_d[cur_sel[1:0]] = stage_shift;
                        end else if (cur_op == OP_WR_STATE) begin
                            sh_en_d  = 1'b1;
                            sh_sel_d = cur_sel;
                            sh_lsb_d = mosi_s;
                        end
                    // the fall right after the command byte must keep the MSB on miso
                    end else if (sclk_fall && cur_op == OP_RD_STATE && cnt_q != 8'd0) begin
                        out_d = {out_q[ST_W-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            cmd_q    <= '0;
            stage_q  <= '0;
            out_q    <= '0;
            for (int i = 0; i < 3; i++) regs_q[i] <= '0;
            mode_q   <= MODE_IDLE;
            ready_q  <= 1'b0;
            sh_en_q  <= 1'b0;
            sh_sel_q <= '0;
            sh_lsb_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cmd_q    <= cmd_d;
            stage_q  <= stage_d;
            out_q    <= out_d;
            regs_q   <= regs_d;
            mode_q   <= mode_d;
            ready_q  <= ready_d;
            sh_en_q  <= sh_en_d;
            sh_sel_q <= sh_sel_d;
            sh_lsb_q <= sh_lsb_d;
        end
    end

    assign miso            = (state_q == ST_DATA && cur_op == OP_RD_STATE) ? out_q[ST_W-1] : 1'b0;
    assign reg0_128b       = regs_q[0];
    assign reg1_128b       = regs_q[1];
    assign reg2_128b       = regs_q[2];
    assign operation_mode  = mode_q;
    assign operation_ready = ready_q;
    assign state_shift_en  = sh_en_q;
    assign state_shift_sel = sh_sel_q;
    assign state_shift_lsb = sh_lsb_q;

    // levels and mosi edges are not needed; the staging MSB is shifted out unread
    logic unused_bits;
    assign unused_bits = ^{sclk_s, cs_s, mosi_rise, mosi_fall, stage_q[REG_W-1]};

endmodule
